// File: rtl/fpu_unit.sv
// Single-cycle IEEE-754 single-precision unit: add/sub, mul, div and sign injection.
// Rounding is truncation, denormals are flushed to zero and the result is registered.
module fpu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  fpu_control,
    input  logic [2:0]  funct3,
    input  logic        fpu_sel,
    output logic [31:0] fpu_result
);

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return n;
    endfunction

    // Restoring division: bit 24 is the integer bit, bits 23:0 the fraction.
    function automatic logic [24:0] div_mant(input logic [23:0] n, input logic [23:0] d);
        logic [24:0] r;
        logic [24:0] q;
        r = {1'b0, n};
        q = 25'h0;
        for (int i = 24; i >= 0; i--) begin
            if (r >= {1'b0, d}) begin
                q[i] = 1'b1;
                r    = r - {1'b0, d};
            end else begin
                q[i] = 1'b0;
            end
            r = r << 1;
        end
        return q;
    endfunction

    // Saturates to infinity on overflow and flushes to signed zero on underflow.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [23:0] m);
        logic [31:0] r;
        if (e >= 10'sd255) begin
            r = {s, 8'hFF, 23'h0};
        end else if (e <= 10'sd0) begin
            r = {s, 31'h0};
        end else begin
            r = {s, e[7:0], m[22:0]};
        end
        return r;
    endfunction

    logic        is_sub_s;
    logic [31:0] b_eff_s, big_s, small_s;
    logic [23:0] big_m_s, small_m_s, small_sh_s;
    logic [7:0]  exp_diff_s;
    logic [24:0] sum_s;
    logic [4:0]  lz_s;
    logic [31:0] add_res_s;

    // Add/subtract: order by magnitude, align, add, renormalise.
    always_comb begin
        is_sub_s   = (fpu_control == 3'b001) || fpu_sel;
        b_eff_s    = is_sub_s ? {~rs2[31], rs2[30:0]} : rs2;
        big_s      = (b_eff_s[30:0] > rs1[30:0]) ? b_eff_s : rs1;
        small_s    = (b_eff_s[30:0] > rs1[30:0]) ? rs1 : b_eff_s;
        big_m_s    = (big_s[30:23] != 8'h00) ? {1'b1, big_s[22:0]} : 24'h0;
        small_m_s  = (small_s[30:23] != 8'h00) ? {1'b1, small_s[22:0]} : 24'h0;
        exp_diff_s = big_s[30:23] - small_s[30:23];
        small_sh_s = small_m_s >> exp_diff_s;
        if (big_s[31] == small_s[31]) begin
            sum_s = {1'b0, big_m_s} + {1'b0, small_sh_s};
        end else begin
            sum_s = {1'b0, big_m_s} - {1'b0, small_sh_s};
        end
        lz_s = lzc24(sum_s[23:0]);
        if (big_s[30:23] == 8'hFF) begin
            add_res_s = big_s;
        end else if (sum_s == 25'h0) begin
            add_res_s = 32'h0000_0000;
        end else if (sum_s[24]) begin
            add_res_s = pack(big_s[31], $signed({2'b00, big_s[30:23]}) + 10'sd1, sum_s[24:1]);
        end else begin
            add_res_s = pack(big_s[31], $signed({2'b00, big_s[30:23]}) - $signed({5'b00000, lz_s}),
                             sum_s[23:0] << lz_s);
        end
    end

    logic        sign_x_s;
    logic [23:0] ma_s, mb_s;
    logic [47:0] prod_s;
    logic [24:0] quot_s;
    logic [31:0] mul_res_s, div_res_s;

    // Multiply and divide share the operand unpacking and special-case checks.
    always_comb begin
        sign_x_s = rs1[31] ^ rs2[31];
        ma_s     = {1'b1, rs1[22:0]};
        mb_s     = {1'b1, rs2[22:0]};
        prod_s   = {24'h0, ma_s} * {24'h0, mb_s};
        quot_s   = div_mant(ma_s, mb_s);
        if (rs1[30:23] == 8'h00 || rs2[30:23] == 8'h00) begin
            mul_res_s = {sign_x_s, 31'h0};
        end else if (rs1[30:23] == 8'hFF || rs2[30:23] == 8'hFF) begin
            mul_res_s = {sign_x_s, 8'hFF, 23'h0};
        end else begin
            mul_res_s = pack(sign_x_s,
                             $signed({2'b00, rs1[30:23]}) + $signed({2'b00, rs2[30:23]})
                             - 10'sd127 + (prod_s[47] ? 10'sd1 : 10'sd0),
                             prod_s[47] ? prod_s[47:24] : prod_s[46:23]);
        end
        if (rs1[30:23] == 8'h00) begin
            div_res_s = {sign_x_s, 31'h0};
        end else if (rs2[30:23] == 8'h00 || rs1[30:23] == 8'hFF || rs2[30:23] == 8'hFF) begin
            div_res_s = {sign_x_s, 8'hFF, 23'h0};
        end else begin
            div_res_s = pack(sign_x_s,
                             $signed({2'b00, rs1[30:23]}) - $signed({2'b00, rs2[30:23]})
                             + 10'sd127 - (quot_s[24] ? 10'sd0 : 10'sd1),
                             quot_s[24] ? quot_s[24:1] : quot_s[23:0]);
        end
    end

    logic [31:0] sgnj_res_s, next_result_s;

    // Sign injection and the operation select.
    always_comb begin
        case (funct3)
            3'b000:  sgnj_res_s = {rs2[31], rs1[30:0]};
            3'b001:  sgnj_res_s = {~rs2[31], rs1[30:0]};
            3'b010:  sgnj_res_s = {rs1[31] ^ rs2[31], rs1[30:0]};
            default: sgnj_res_s = rs1;
        endcase
        case (fpu_control)
            3'b000:  next_result_s = add_res_s;
            3'b001:  next_result_s = add_res_s;
            3'b010:  next_result_s = mul_res_s;
            3'b011:  next_result_s = div_res_s;
            3'b100:  next_result_s = sgnj_res_s;
            default: next_result_s = 32'h0000_0000;
        endcase
    end

    // Result register, the only state in the unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_result <= 32'h0000_0000;
        end else begin
            fpu_result <= next_result_s;
        end
    end

endmodule

// File: tb/tb_fpu_unit.sv
// Directed, table-driven bench for fpu_unit with hand-computed expected results.
module tb_fpu_unit;

    logic        clk;
    logic        rst;
    logic [31:0] rs1, rs2;
    logic [2:0]  fpu_control, funct3;
    logic        fpu_sel;
    logic [31:0] fpu_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [2:0]  f3;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    fpu_unit dut (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .fpu_control(fpu_control),
        .funct3(funct3), .fpu_sel(fpu_sel), .fpu_result(fpu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [2:0] f, input logic s);
        @(negedge clk);
        rs1 = a; rs2 = b; fpu_control = c; funct3 = f; fpu_sel = s;
    endtask

    initial begin
        // add / sub
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b000, 3'b000, 1'b0, 32'h40ECCCCC});
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b001, 3'b000, 1'b1, 32'hBF800000});
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b001, 3'b000, 1'b0, 32'hBF800000});
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b000, 3'b000, 1'b1, 32'hBF800000});
        vecs.push_back('{32'hBF000000, 32'hBF000000, 3'b001, 3'b000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h3F800000, 32'h3F800000, 3'b000, 3'b000, 1'b0, 32'h40000000});
        vecs.push_back('{32'h3F800000, 32'h00000000, 3'b000, 3'b000, 1'b0, 32'h3F800000});
        vecs.push_back('{32'h80000000, 32'h80000000, 3'b000, 3'b000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h40000000, 32'h3F800000, 3'b001, 3'b000, 1'b0, 32'h3F800000});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 3'b000, 3'b000, 1'b0, 32'h7F800000});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 3'b000, 1'b0, 32'h7F800000});
        // mul
        vecs.push_back('{32'hBF000000, 32'hC0CCCCCC, 3'b010, 3'b000, 1'b0, 32'h404CCCCC});
        vecs.push_back('{32'hBF000000, 32'h40CCCCCC, 3'b010, 3'b000, 1'b0, 32'hC04CCCCC});
        vecs.push_back('{32'h3F800000, 32'h80000000, 3'b010, 3'b000, 1'b0, 32'h80000000});
        vecs.push_back('{32'h7F000000, 32'h7F000000, 3'b010, 3'b000, 1'b0, 32'h7F800000});
        vecs.push_back('{32'h00800000, 32'h00800000, 3'b010, 3'b000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h40000000, 32'h40400000, 3'b010, 3'b000, 1'b0, 32'h40C00000});
        // div
        vecs.push_back('{32'hC0CCCCCC, 32'hBF000000, 3'b011, 3'b000, 1'b0, 32'h414CCCCC});
        vecs.push_back('{32'h3F800000, 32'h00000000, 3'b011, 3'b000, 1'b0, 32'h7F800000});
        vecs.push_back('{32'hBF800000, 32'h00000000, 3'b011, 3'b000, 1'b0, 32'hFF800000});
        vecs.push_back('{32'h80000000, 32'h3F800000, 3'b011, 3'b000, 1'b0, 32'h80000000});
        vecs.push_back('{32'h3F800000, 32'h40000000, 3'b011, 3'b000, 1'b0, 32'h3F000000});
        vecs.push_back('{32'h3F800000, 32'h40400000, 3'b011, 3'b000, 1'b0, 32'h3EAAAAAA});
        // sign injection and unused codes
        vecs.push_back('{32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b000, 1'b0, 32'h3F000000});
        vecs.push_back('{32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b001, 1'b0, 32'hBF000000});
        vecs.push_back('{32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b010, 1'b0, 32'hBF000000});
        vecs.push_back('{32'h3F000000, 32'hC0CCCCCC, 3'b100, 3'b010, 1'b0, 32'hBF000000});
        vecs.push_back('{32'hBF000000, 32'h40CCCCCC, 3'b100, 3'b011, 1'b0, 32'hBF000000});
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b101, 3'b000, 1'b0, 32'h00000000});
        vecs.push_back('{32'h404CCCCC, 32'h40866666, 3'b111, 3'b000, 1'b0, 32'h00000000});

        rst = 1'b1;
        rs1 = 32'h3F800000; rs2 = 32'h3F800000; fpu_control = 3'b000; funct3 = 3'b000; fpu_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset_value", fpu_result, 32'h00000000);

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].f3, vecs[i].sel);
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), fpu_result, vecs[i].exp);
        end

        // Inputs changed between edges must not reach the output early.
        drive(32'hBF000000, 32'hC0CCCCCC, 3'b010, 3'b000, 1'b0);
        @(posedge clk);
        #1 rs1 = 32'h3F800000; rs2 = 32'h3F800000; fpu_control = 3'b000;
        #2 check("hold_between_edges", fpu_result, 32'h404CCCCC);
        @(posedge clk);
        #1 check("new_op_next_edge", fpu_result, 32'h40000000);

        // Back-to-back operations, one per cycle.
        drive(32'h3F800000, 32'h40000000, 3'b011, 3'b000, 1'b0);
        @(posedge clk);
        #1 check("b2b_first", fpu_result, 32'h3F000000);
        rs1 = 32'hBF000000; rs2 = 32'h40CCCCCC; fpu_control = 3'b100; funct3 = 3'b000;
        @(posedge clk);
        #1 check("b2b_second", fpu_result, 32'h3F000000);

        // Mid-stream reset discards the sampled add, release registers it.
        drive(32'h404CCCCC, 32'h40866666, 3'b000, 3'b000, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("reset_midstream", fpu_result, 32'h00000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("after_reset_release", fpu_result, 32'h40ECCCCC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
